fetch_sequencer: RTL



---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    localparam int PC_W   = 12;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    // BOOT is a single idle cycle after reset so the IM sees a settled
    // address before the first capture.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory port and decode handshake of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int PC_W = 12
);
    logic [PC_W-1:0] im_addr;
    logic [31:0]     im_data;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output im_addr,
        input  im_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  im_addr,
        output im_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries. The head is read straight out of
// register storage, so there is no path from the write data to the head.
module fetch_fifo #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [31:0]                push_inst,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [PC_W-1:0]            head_pc,
    output logic [31:0]                head_inst
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  mem_pc   [DEPTH];
    logic [31:0]      mem_inst [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    // Pointers and occupancy; flush discards everything including a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= cpu_pkg::NOP;
            end
        end else if (push && !flush) begin
            mem_pc[wr_ptr]   <= push_pc;
            mem_inst[wr_ptr] <= push_inst;
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_pc   = mem_pc[rd_ptr];
    assign head_inst = mem_inst[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC register, IM capture into a prefetch
// FIFO, redirect flush and halt/resume sequencing.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_BOOT   | one idle cycle after reset, redirects ignored
// ST_RUN    | fetching one word per cycle when FIFO has room
// ST_HALTED | no fetch; buffered words still drain to decode
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2,
    parameter int              CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    bus,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 halt,
    input  logic                 resume,
    output logic                 halted,
    output logic [CNT_W-1:0]     fetch_cnt
);
    localparam int FCNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [PC_W-1:0]   fetch_pc;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic              push;
    logic              pop;
    logic              flush;
    logic              fifo_full;
    logic [FCNT_W-1:0] fifo_count;
    logic [PC_W-1:0]   head_pc;
    logic [31:0]       head_inst;

    assign pop   = bus.inst_valid & bus.inst_ready;
    assign flush = redirect_valid & (state_q != ST_BOOT);
    assign push  = (state_q == ST_RUN) & ~halt & ~redirect_valid & (~fifo_full | pop);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic; halt dominates a simultaneous resume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_HALTED;
            ST_HALTED: if (resume && !halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Fetch PC: redirect overrides sequential advance, which wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     fetch_pc <= RESET_PC;
        else if (flush) fetch_pc <= word_align(redirect_pc);
        else if (push)  fetch_pc <= fetch_pc + PC_W'(4);
    end

    // Count of words written into the FIFO since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    fetch_cnt_q <= '0;
        else if (push) fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end

    fetch_fifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_pc   (fetch_pc),
        .push_inst (bus.im_data),
        .full      (fifo_full),
        .count     (fifo_count),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

    assign bus.im_addr    = fetch_pc;
    assign bus.inst_valid = (fifo_count != '0);
    assign bus.inst       = head_inst;
    assign bus.inst_pc    = head_pc;
    assign halted         = (state_q == ST_HALTED);
    assign fetch_cnt      = fetch_cnt_q;

endmodule
